// File: rtl/prism_sp_rx_irq_moderator_pkg.sv
// Shared configuration for the SP unit RX interrupt moderator.
// Holds the per-queue moderation state encoding and the default
// threshold/timeout values used when integrating the moderator.
package sp_unit_config;

  typedef enum logic [1:0] {
    IRQ_MOD_IDLE,
    IRQ_MOD_ACCUM,
    IRQ_MOD_ASSERTED
  } irq_mod_state_t;

  localparam int unsigned IRQ_MOD_DEF_PKT_THRESHOLD = 16;
  localparam int unsigned IRQ_MOD_DEF_TIMEOUT       = 1024;

endpackage

// File: rtl/prism_sp_rx_irq_queue_ctl.sv
// Per-queue RX interrupt coalescing controller.
// Counts rxdone pulses and cycles since the first unreported packet and
// raises o_irq_status once the packet threshold or the timeout is reached.
// Ports:
//   i_clock, i_resetn      clock, async active-low reset
//   i_rxdone               one-cycle pulse per completed RX descriptor
//   i_cfg_enable           moderation enable; low forces IDLE and clears all
//   i_cfg_pkt_threshold    packet count that asserts (0 behaves as 1)
//   i_cfg_timeout          cycles from first packet to assertion (0 = off)
//   i_irq_ack              write-1-to-clear pulse, honoured only in ASSERTED
//   o_irq_status           registered asserted flag
//   o_pending_count        current packet counter
module prism_sp_rx_irq_queue_ctl
  import sp_unit_config::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_resetn,
  input  logic                   i_rxdone,
  input  logic                   i_cfg_enable,
  input  logic [COUNT_WIDTH-1:0] i_cfg_pkt_threshold,
  input  logic [TIMER_WIDTH-1:0] i_cfg_timeout,
  input  logic                   i_irq_ack,
  output logic                   o_irq_status,
  output logic [COUNT_WIDTH-1:0] o_pending_count
);

  irq_mod_state_t         r_state, w_state_nx;
  logic [COUNT_WIDTH-1:0] r_count, w_count_nx;
  logic [TIMER_WIDTH-1:0] r_timer, w_timer_nx;
  logic                   r_status, w_status_nx;

  logic [COUNT_WIDTH-1:0] w_thr_eff;
  logic [COUNT_WIDTH-1:0] w_cnt_upd;
  logic [TIMER_WIDTH-1:0] w_tmr_inc;
  logic                   w_timeout_hit;

  always_comb begin
    w_thr_eff = i_cfg_pkt_threshold;
    if (i_cfg_pkt_threshold == '0) w_thr_eff = COUNT_WIDTH'(1);

    // Saturating increments: neither counter ever wraps.
    w_cnt_upd = r_count;
    if (i_rxdone && (r_count != '1)) w_cnt_upd = r_count + COUNT_WIDTH'(1);
    w_tmr_inc = r_timer;
    if (r_timer != '1) w_tmr_inc = r_timer + TIMER_WIDTH'(1);

    w_timeout_hit = (i_cfg_timeout != '0) && (w_tmr_inc == i_cfg_timeout);
  end

  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_timer_nx  = r_timer;
    w_status_nx = r_status;

    unique case (r_state)
      IRQ_MOD_IDLE: begin
        w_count_nx  = '0;
        w_timer_nx  = '0;
        w_status_nx = 1'b0;
        if (i_rxdone) begin
          if (w_thr_eff <= COUNT_WIDTH'(1)) begin
            w_state_nx  = IRQ_MOD_ASSERTED;
            w_status_nx = 1'b1;
          end else begin
            w_state_nx = IRQ_MOD_ACCUM;
            w_count_nx = COUNT_WIDTH'(1);
          end
        end
      end
      IRQ_MOD_ACCUM: begin
        // Packets arriving on the asserting edge belong to the reported batch.
        if ((w_cnt_upd >= w_thr_eff) || w_timeout_hit) begin
          w_state_nx  = IRQ_MOD_ASSERTED;
          w_status_nx = 1'b1;
          w_count_nx  = '0;
          w_timer_nx  = '0;
        end else begin
          w_count_nx = w_cnt_upd;
          w_timer_nx = w_tmr_inc;
        end
      end
      IRQ_MOD_ASSERTED: begin
        w_timer_nx = '0;
        w_count_nx = w_cnt_upd;
        if (i_irq_ack) begin
          w_status_nx = 1'b0;
          w_state_nx  = (w_cnt_upd != '0) ? IRQ_MOD_ACCUM : IRQ_MOD_IDLE;
        end
      end
      default: begin
        w_state_nx  = IRQ_MOD_IDLE;
        w_count_nx  = '0;
        w_timer_nx  = '0;
        w_status_nx = 1'b0;
      end
    endcase

    if (!i_cfg_enable) begin
      w_state_nx  = IRQ_MOD_IDLE;
      w_count_nx  = '0;
      w_timer_nx  = '0;
      w_status_nx = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= IRQ_MOD_IDLE;
      r_count  <= '0;
      r_timer  <= '0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_timer  <= w_timer_nx;
      r_status <= w_status_nx;
    end
  end

  assign o_irq_status    = r_status;
  assign o_pending_count = r_count;

endmodule

// File: rtl/prism_sp_rx_irq_moderator.sv
// RX interrupt moderation controller for the duo RX top.
// One coalescing controller per RX queue; irq is the OR of their status bits
// and drives gem_irq_rx.
// Ports:
//   clock, resetn       clock, async active-low reset
//   rxdone              per-queue completion pulses
//   cfg_enable          per-queue moderation enable
//   cfg_pkt_threshold   shared packet-count threshold
//   cfg_timeout         shared timeout in cycles (0 = off)
//   irq_ack             per-queue write-1-to-clear
//   irq_status          per-queue asserted flags
//   pending_count       per-queue counters, queue q at [q*COUNT_WIDTH +: COUNT_WIDTH]
//   irq                 OR of irq_status
module prism_sp_rx_irq_moderator
  import sp_unit_config::*;
#(
  parameter int unsigned NUM_QUEUES  = 2,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [NUM_QUEUES-1:0]             rxdone,
  input  logic [NUM_QUEUES-1:0]             cfg_enable,
  input  logic [COUNT_WIDTH-1:0]            cfg_pkt_threshold,
  input  logic [TIMER_WIDTH-1:0]            cfg_timeout,
  input  logic [NUM_QUEUES-1:0]             irq_ack,
  output logic [NUM_QUEUES-1:0]             irq_status,
  output logic [NUM_QUEUES*COUNT_WIDTH-1:0] pending_count,
  output logic                              irq
);

  logic [NUM_QUEUES-1:0] w_status;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    prism_sp_rx_irq_queue_ctl #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .TIMER_WIDTH (TIMER_WIDTH)
    ) u_ctl (
      .i_clock             (clock),
      .i_resetn            (resetn),
      .i_rxdone            (rxdone[q]),
      .i_cfg_enable        (cfg_enable[q]),
      .i_cfg_pkt_threshold (cfg_pkt_threshold),
      .i_cfg_timeout       (cfg_timeout),
      .i_irq_ack           (irq_ack[q]),
      .o_irq_status        (w_status[q]),
      .o_pending_count     (pending_count[q*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  assign irq_status = w_status;
  assign irq        = |w_status;

endmodule
